framebuffer_pingpong: RTL and testbench

Double-buffered framebuffer write controller on rgbClk, directly downstream of the RGB565 pixel packer. Takes packed pixels plus a frame-start marker, writes each frame into the back bank of a two-bank pixel RAM and publishes completed frames to the LED-driver read side via a valid/consumed handshake. It never overwrites the bank being read. It drops stale frames when the reader is slow.

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_sat_counter.sv | 23 ++
 rtl/framebuffer_pingpong.sv | 171 +++++++++++++++++
 tb/tb_framebuffer_pingpong.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and state type for the ping-pong framebuffer write controller.
package fb_pkg;

  localparam int unsigned IMAGE_SIZE     = 3840;
  localparam int unsigned PIX_ADDR_WIDTH = 12;
  localparam int unsigned PIX_DATA_WIDTH = 16;
  localparam int unsigned CNT_WIDTH      = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module fb_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             rgbClk,
  input  logic             nrst,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge rgbClk or negedge nrst) begin
    if (!nrst) begin
      value_q <= '0;
    end else if (inc && (value_q != '1)) begin
      value_q <= value_q + WIDTH'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/framebuffer_pingpong.sv
// Double-buffered framebuffer write controller with frame publish/consume handshake.
// Optional FB_FRAME_CHECK_EN: strict frame-length check and badFrameCount.
module framebuffer_pingpong #(
  parameter int unsigned IMAGE_SIZE     = fb_pkg::IMAGE_SIZE,
  parameter int unsigned PIX_ADDR_WIDTH = fb_pkg::PIX_ADDR_WIDTH,
  parameter int unsigned PIX_DATA_WIDTH = fb_pkg::PIX_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH      = fb_pkg::CNT_WIDTH
) (
  input  logic                      rgbClk,
  input  logic                      nrst,
  input  logic [PIX_DATA_WIDTH-1:0] pixData,
  input  logic                      pixValid,
  input  logic                      frameStart,
  input  logic                      frameConsumed,
  output logic [PIX_ADDR_WIDTH:0]   memAddr,
  output logic [PIX_DATA_WIDTH-1:0] memData,
  output logic                      memWe,
  output logic                      frontBank,
  output logic                      frontValid,
  output logic [CNT_WIDTH-1:0]      dropCount,
  output logic [CNT_WIDTH-1:0]      badFrameCount
);

  import fb_pkg::*;

  // One extra bit so the count can represent IMAGE_SIZE == 2**PIX_ADDR_WIDTH.
  localparam int unsigned PCNT_W = PIX_ADDR_WIDTH + 1;

  fb_state_t                 state_q, state_d;
  logic [PCNT_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic                      front_bank_q, front_bank_d;
  logic                      front_valid_q, front_valid_d;
  logic [PIX_ADDR_WIDTH:0]   mem_addr_q, mem_addr_d;
  logic [PIX_DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                      mem_we_q, mem_we_d;
  logic [PCNT_W-1:0]         cnt_base_c;
  logic                      frame_active_c;
  logic                      complete_c;
  logic                      drop_inc_c;
`ifdef FB_FRAME_CHECK_EN
  logic                      ovf_q, ovf_d;
  logic                      bad_inc_c;

  assign complete_c = (pix_cnt_q == PCNT_W'(IMAGE_SIZE)) && !ovf_q;
`else
  assign complete_c = (pix_cnt_q != '0);
`endif

  always_ff @(posedge rgbClk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      front_bank_q  <= 1'b0;
      front_valid_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_we_q      <= 1'b0;
`ifdef FB_FRAME_CHECK_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      front_bank_q  <= front_bank_d;
      front_valid_q <= front_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_we_q      <= mem_we_d;
`ifdef FB_FRAME_CHECK_EN
      ovf_q         <= ovf_d;
`endif
    end
  end

  // Consume is applied before frame evaluation so a coincident frameStart can swap.
  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    front_bank_d   = front_bank_q;
    front_valid_d  = front_valid_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    mem_we_d       = 1'b0;
    cnt_base_c     = pix_cnt_q;
    frame_active_c = 1'b0;
    drop_inc_c     = 1'b0;
`ifdef FB_FRAME_CHECK_EN
    ovf_d          = ovf_q;
    bad_inc_c      = 1'b0;
`endif

    if (frameConsumed) begin
      front_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (frameStart) begin
          state_d        = WRITE;
          frame_active_c = 1'b1;
          cnt_base_c     = '0;
`ifdef FB_FRAME_CHECK_EN
          ovf_d          = 1'b0;
`endif
        end
      end
      WRITE: begin
        frame_active_c = 1'b1;
        if (frameStart) begin
          if (complete_c) begin
            if (!front_valid_d) begin
              front_bank_d  = ~front_bank_q;
              front_valid_d = 1'b1;
            end else begin
              drop_inc_c = 1'b1;
            end
          end else begin
`ifdef FB_FRAME_CHECK_EN
            bad_inc_c = 1'b1;
`endif
          end
          cnt_base_c = '0;
`ifdef FB_FRAME_CHECK_EN
          ovf_d      = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    pix_cnt_d = cnt_base_c;
    // Pixels go to the back bank as it stands after any swap this cycle.
    if (frame_active_c && pixValid) begin
      if (cnt_base_c < PCNT_W'(IMAGE_SIZE)) begin
        mem_we_d   = 1'b1;
        mem_addr_d = {~front_bank_d, cnt_base_c[PIX_ADDR_WIDTH-1:0]};
        mem_data_d = pixData;
        pix_cnt_d  = cnt_base_c + PCNT_W'(1);
      end else begin
`ifdef FB_FRAME_CHECK_EN
        ovf_d = 1'b1;
`endif
      end
    end
  end

  fb_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .rgbClk (rgbClk),
    .nrst   (nrst),
    .inc    (drop_inc_c),
    .value  (dropCount)
  );

`ifdef FB_FRAME_CHECK_EN
  fb_sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_cnt (
    .rgbClk (rgbClk),
    .nrst   (nrst),
    .inc    (bad_inc_c),
    .value  (badFrameCount)
  );
`else
  assign badFrameCount = '0;
`endif

  assign memAddr    = mem_addr_q;
  assign memData    = mem_data_q;
  assign memWe      = mem_we_q;
  assign frontBank  = front_bank_q;
  assign frontValid = front_valid_q;

endmodule

// File: tb/tb_framebuffer_pingpong.sv
// Directed bench for framebuffer_pingpong; expectations follow FB_FRAME_CHECK_EN if defined.
module tb_framebuffer_pingpong;

  localparam int IMG = 3840;

  logic        rgbClk = 1'b0;
  logic        nrst;
  logic [15:0] pixData;
  logic        pixValid;
  logic        frameStart;
  logic        frameConsumed;
  logic [12:0] memAddr;
  logic [15:0] memData;
  logic        memWe;
  logic        frontBank;
  logic        frontValid;
  logic [7:0]  dropCount;
  logic [7:0]  badFrameCount;

  int n_checks = 0;
  int n_errors = 0;

  logic exp_fb, exp_fv;
  int   exp_drop, exp_bad;

  framebuffer_pingpong dut (
    .rgbClk        (rgbClk),
    .nrst          (nrst),
    .pixData       (pixData),
    .pixValid      (pixValid),
    .frameStart    (frameStart),
    .frameConsumed (frameConsumed),
    .memAddr       (memAddr),
    .memData       (memData),
    .memWe         (memWe),
    .frontBank     (frontBank),
    .frontValid    (frontValid),
    .dropCount     (dropCount),
    .badFrameCount (badFrameCount)
  );

  always #5 rgbClk = ~rgbClk;

  function automatic logic [15:0] pix(input int i);
    return 16'(i * 37 + 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rgbClk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, " frontBank"}, 32'(frontBank), 32'(exp_fb));
    check({tag, " frontValid"}, 32'(frontValid), 32'(exp_fv));
    check({tag, " dropCount"}, 32'(dropCount), 32'(exp_drop));
    check({tag, " badFrameCount"}, 32'(badFrameCount), 32'(exp_bad));
  endtask

  // n pixels starting at index start; writes expected only below IMG.
  task automatic pixels(input int n, input logic bank, input int start, input logic expect_we);
    for (int i = 0; i < n; i++) begin
      pixValid = 1'b1;
      pixData  = pix(start + i);
      tick();
      if (expect_we && (start + i) < IMG)
        check("pixel write", {2'b0, memWe, memAddr, memData},
              {2'b0, 1'b1, bank, 12'(start + i), pix(start + i)});
      else
        check("pixel no-write", 32'(memWe), 32'd0);
    end
    pixValid = 1'b0;
  endtask

  task automatic fs(input logic cons, input logic pv);
    frameStart    = 1'b1;
    frameConsumed = cons;
    pixValid      = pv;
    pixData       = pix(0);
    tick();
    frameStart    = 1'b0;
    frameConsumed = 1'b0;
    pixValid      = 1'b0;
  endtask

  task automatic consume();
    frameConsumed = 1'b1;
    tick();
    frameConsumed = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; pixData = '0; pixValid = 1'b0; frameStart = 1'b0; frameConsumed = 1'b0;
    exp_fb = 1'b0; exp_fv = 1'b0; exp_drop = 0; exp_bad = 0;
    repeat (3) @(posedge rgbClk);
    #1;
    check("reset memAddr", 32'(memAddr), 32'd0);
    check("reset memData", 32'(memData), 32'd0);
    check("reset memWe", 32'(memWe), 32'd0);
    check_status("reset");
    @(negedge rgbClk) nrst = 1'b1;

    // Idle ignores pixels
    tick();
    pixels(5, 1'b1, 0, 1'b0);

    // Frame 1 into bank 1, then publish
    fs(1'b0, 1'b0);
    check_status("first start");
    pixels(IMG, 1'b1, 0, 1'b1);
    tick();
    check("idle gap memWe", 32'(memWe), 32'd0);
    fs(1'b0, 1'b0);
    exp_fb = 1'b1; exp_fv = 1'b1;
    check_status("frame1 published");

    // Frame 2 without consume: dropped, bank 0 rewritten
    pixels(IMG, 1'b0, 0, 1'b1);
    fs(1'b0, 1'b0);
    exp_drop = 1;
    check_status("frame2 dropped");

    // Frame 3 ends with coincident consume; pixel 0 of frame 4 lands in new back bank 1
    pixels(IMG, 1'b0, 0, 1'b1);
    fs(1'b1, 1'b1);
    exp_fb = 1'b0; exp_fv = 1'b1;
    check_status("consume+start swap");
    check("pixel0 on start", {2'b0, memWe, memAddr, memData}, {2'b0, 1'b1, 1'b1, 12'd0, pix(0)});
    consume();
    exp_fv = 1'b0;
    check_status("consume");

    // Short frame of 100 pixels
    pixels(99, 1'b1, 1, 1'b1);
    fs(1'b0, 1'b0);
`ifdef FB_FRAME_CHECK_EN
    exp_bad = 1;
`else
    exp_fb = 1'b1; exp_fv = 1'b1;
`endif
    check_status("short frame");
    consume();
    exp_fv = 1'b0;
    check_status("consume2");

    // Long frame of 3841 pixels: last one suppressed
    pixels(IMG + 1, ~exp_fb, 0, 1'b1);
    fs(1'b0, 1'b0);
`ifdef FB_FRAME_CHECK_EN
    exp_bad = 2;
`else
    exp_fb = ~exp_fb; exp_fv = 1'b1;
`endif
    check_status("long frame");

    // Zero-pixel frame
    fs(1'b0, 1'b0);
`ifdef FB_FRAME_CHECK_EN
    exp_bad = 3;
`endif
    check_status("empty frame");

    // Async reset mid-frame
    pixels(2000, ~exp_fb, 0, 1'b1);
    #2 nrst = 1'b0;
    #1;
    exp_fb = 1'b0; exp_fv = 1'b0; exp_drop = 0; exp_bad = 0;
    check("async reset memAddr", 32'(memAddr), 32'd0);
    check("async reset memData", 32'(memData), 32'd0);
    check("async reset memWe", 32'(memWe), 32'd0);
    check_status("async reset");
    @(negedge rgbClk) nrst = 1'b1;
    tick();
    pixels(10, 1'b1, 0, 1'b0);
    fs(1'b0, 1'b1);
    check("resume pixel0", {2'b0, memWe, memAddr, memData}, {2'b0, 1'b1, 1'b1, 12'd0, pix(0)});

    // Back-to-back one-pixel frames drive a counter into saturation
    for (int k = 0; k < 260; k++) fs(1'b0, 1'b1);
`ifdef FB_FRAME_CHECK_EN
    exp_bad = 255;
`else
    exp_fb = 1'b1; exp_fv = 1'b1; exp_drop = 255;
`endif
    check_status("saturation");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
